frame_pattern_writer: RTL and testbench

Parametrised successor to the single-mode band drawer. Renders one full test-pattern frame into the back framebuffer in SDRAM over the simple request/done memory port, packing several pixels per write word. Waits for a vertical-sync rising edge, then swaps buffers and optionally writes the new front-buffer index to the video controller's control register. Sits between the SDRAM arbiter client port and the video scan-out logic.

---
 rtl/frame_pattern_pkg.sv | 32 +++
 rtl/frame_pattern_writer_pixel.sv | 40 ++++
 rtl/frame_pattern_writer.sv | 181 ++++++++++++++++++
 tb/tb_frame_pattern_writer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pattern_pkg.sv
`default_nettype none
// ============================================================================
// frame_pattern_pkg
// Shared types for the frame pattern writer: FSM states, pattern mode
// encodings and the pixels-per-word derivation.
// Rev 1.0
// ============================================================================
package frame_pattern_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ROW_START  = 3'd1,
    S_PIX_REQ    = 3'd2,
    S_PIX_WAIT   = 3'd3,
    S_FRAME_END  = 3'd4,
    S_WAIT_VSYNC = 3'd5,
    S_CTRL_REQ   = 3'd6,
    S_CTRL_WAIT  = 3'd7
  } state_t;

  localparam logic [1:0] MODE_SOLID   = 2'd0;
  localparam logic [1:0] MODE_BANDS   = 2'd1;
  localparam logic [1:0] MODE_CHECKER = 2'd2;
  localparam logic [1:0] MODE_VGRAD   = 2'd3;

  // Number of pixels packed into one memory word.
  function automatic int calc_ppw(input int data_w, input int pix_w);
    return data_w / pix_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_pattern_writer_pixel.sv
`default_nettype none
// ============================================================================
// pattern_pixel
// Combinational value of one test-pattern pixel at (x, y).
// Rev 1.0
// ============================================================================
module pattern_pixel
  import frame_pattern_pkg::*;
#(
  parameter int V_RES     = 480,
  parameter int PIX_W     = 8,
  parameter int CHK_SHIFT = 5
) (
  input  logic [1:0]       mode,
  input  logic [15:0]      x,
  input  logic [15:0]      y,
  input  logic [15:0]      shift,
  input  logic [PIX_W-1:0] color_a,
  input  logic [PIX_W-1:0] color_b,
  output logic [PIX_W-1:0] pix
);

  localparam logic [15:0] LAST_ROW = 16'(V_RES - 1);

  // Select the pattern; arithmetic results are truncated to the pixel width.
  always_comb begin
    pix = color_a;
    case (mode)
      MODE_SOLID:   pix = color_a;
      MODE_BANDS: begin
        if (y == 16'd0 || y == LAST_ROW) pix = '1;
        else                             pix = PIX_W'(x + y + shift);
      end
      MODE_CHECKER: pix = (x[CHK_SHIFT] ^ y[CHK_SHIFT]) ? color_b : color_a;
      default:      pix = PIX_W'(y + shift);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/frame_pattern_writer.sv
`default_nettype none
// ============================================================================
// frame_pattern_writer
// Renders a test-pattern frame into the back framebuffer, waits for vsync,
// swaps buffers and reports the new front buffer to the video controller.
// Rev 1.0
// ============================================================================
module frame_pattern_writer
  import frame_pattern_pkg::*;
#(
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter int          PIX_W      = 8,
  parameter int          DATA_W     = 32,
  parameter int          ROW_SHIFT  = 10,
  parameter logic [31:0] FB_BASE    = 32'h40C00000,
  parameter logic [31:0] BUF_STRIDE = 32'h00100000,
  parameter bit          CTRL_EN    = 1'b1,
  parameter logic [31:0] CTRL_ADDR  = 32'h82003000,
  parameter int          CHK_SHIFT  = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [PIX_W-1:0]    color_a,
  input  logic [PIX_W-1:0]    color_b,
  input  logic                vsync,
  output logic [31:0]         sd_addr,
  output logic                sd_rw,
  output logic [DATA_W-1:0]   sd_data_in,
  output logic                sd_in_valid,
  output logic [DATA_W/8-1:0] sd_wmask,
  input  logic [DATA_W-1:0]   sd_data_out,
  input  logic                sd_done,
  output logic                fbuffer,
  output logic [15:0]         frame_count,
  output logic                busy
);

  localparam int          PPW       = calc_ppw(DATA_W, PIX_W);
  localparam logic [15:0] H_END     = 16'(H_RES);
  localparam logic [15:0] V_END     = 16'(V_RES);
  localparam logic [15:0] SHIFT_MAX = 16'(H_RES - 1);
  localparam logic [15:0] X_STEP    = 16'(PPW);

  state_t            state;
  logic [1:0]        cur_mode;
  logic [15:0]       x;
  logic [15:0]       y;
  logic [15:0]       shift;
  logic [15:0]       x_next;
  logic [31:0]       back_base;
  logic [31:0]       pix_addr;
  logic [DATA_W-1:0] pix_word;
  logic              vs_meta;
  logic              vs_sync;
  logic              vs_prev;
  logic              vs_rise;
  logic              unused_read_data;

  // Write-only client: read data is never consumed.
  assign unused_read_data = ^sd_data_out;

  assign sd_rw    = 1'b1;
  assign sd_wmask = '1;
  assign busy     = (state != S_IDLE);

  // The back buffer is the one not currently scanned out.
  assign back_base = FB_BASE + (fbuffer ? 32'd0 : BUF_STRIDE);
  assign pix_addr  = back_base + ({16'd0, y} << ROW_SHIFT)
                   + ((32'(x) * 32'(PIX_W)) >> 3);
  assign x_next    = x + X_STEP;
  assign vs_rise   = vs_sync & ~vs_prev;

  // One pattern evaluator per pixel lane of the write word.
  for (genvar k = 0; k < PPW; k++) begin : g_pix
    pattern_pixel #(
      .V_RES     (V_RES),
      .PIX_W     (PIX_W),
      .CHK_SHIFT (CHK_SHIFT)
    ) u_pix (
      .mode    (cur_mode),
      .x       (x + 16'(k)),
      .y       (y),
      .shift   (shift),
      .color_a (color_a),
      .color_b (color_b),
      .pix     (pix_word[k*PIX_W +: PIX_W])
    );
  end

  // Two-flop synchroniser plus edge register for the asynchronous vsync.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  // Frame rendering, buffer swap and control-register write sequencer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cur_mode    <= MODE_SOLID;
      x           <= '0;
      y           <= '0;
      shift       <= '0;
      sd_addr     <= '0;
      sd_data_in  <= '0;
      sd_in_valid <= 1'b0;
      fbuffer     <= 1'b0;
      frame_count <= '0;
    end else begin
      sd_in_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            cur_mode <= mode;
            x        <= '0;
            y        <= '0;
            state    <= S_ROW_START;
          end
        end
        S_ROW_START: begin
          if (y == V_END) begin
            state <= S_FRAME_END;
          end else begin
            x     <= '0;
            state <= S_PIX_REQ;
          end
        end
        S_PIX_REQ: begin
          sd_addr     <= pix_addr;
          sd_data_in  <= pix_word;
          sd_in_valid <= 1'b1;
          state       <= S_PIX_WAIT;
        end
        S_PIX_WAIT: begin
          if (sd_done) begin
            x <= x_next;
            if (x_next == H_END) begin
              y     <= y + 16'd1;
              state <= S_ROW_START;
            end else begin
              state <= S_PIX_REQ;
            end
          end
        end
        S_FRAME_END: begin
          shift <= (shift == SHIFT_MAX) ? 16'd0 : shift + 16'd1;
          state <= S_WAIT_VSYNC;
        end
        S_WAIT_VSYNC: begin
          if (vs_rise) begin
            fbuffer     <= ~fbuffer;
            frame_count <= frame_count + 16'd1;
            state       <= CTRL_EN ? S_CTRL_REQ : S_IDLE;
          end
        end
        S_CTRL_REQ: begin
          sd_addr     <= CTRL_ADDR;
          sd_data_in  <= DATA_W'(fbuffer);
          sd_in_valid <= 1'b1;
          state       <= S_CTRL_WAIT;
        end
        S_CTRL_WAIT: begin
          if (sd_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_pattern_writer.sv
`default_nettype none
// ============================================================================
// tb_frame_pattern_writer
// Scoreboard bench: expected memory writes are queued as frames are set up
// and compared against every request strobe issued by the writer.
// Rev 1.0
// ============================================================================
module tb_frame_pattern_writer;

  localparam int          H       = 64;
  localparam int          V       = 40;
  localparam int          PIX_W   = 8;
  localparam int          DATA_W  = 32;
  localparam int          PPW     = DATA_W / PIX_W;
  localparam logic [31:0] FB_BASE = 32'h40C00000;
  localparam logic [31:0] STRIDE  = 32'h00100000;
  localparam logic [31:0] CTRL_A  = 32'h82003000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [1:0]        mode;
  logic [7:0]        color_a;
  logic [7:0]        color_b;
  logic              vsync;
  logic [31:0]       sd_addr;
  logic              sd_rw;
  logic [31:0]       sd_data_in;
  logic              sd_in_valid;
  logic [3:0]        sd_wmask;
  logic [31:0]       sd_data_out;
  logic              sd_done;
  logic              fbuffer;
  logic [15:0]       frame_count;
  logic              busy;

  exp_t              exp_q[$];
  logic [31:0]       seen [logic [31:0]];
  int                n_checks = 0;
  int                n_errors = 0;
  int                n_req    = 0;
  int                done_delay = 0;
  logic              mdl_fbuf = 1'b0;
  logic [15:0]       mdl_count = 16'd0;
  int                mdl_shift = 0;

  frame_pattern_writer #(
    .H_RES (H),
    .V_RES (V)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .color_a     (color_a),
    .color_b     (color_b),
    .vsync       (vsync),
    .sd_addr     (sd_addr),
    .sd_rw       (sd_rw),
    .sd_data_in  (sd_data_in),
    .sd_in_valid (sd_in_valid),
    .sd_wmask    (sd_wmask),
    .sd_data_out (sd_data_out),
    .sd_done     (sd_done),
    .fbuffer     (fbuffer),
    .frame_count (frame_count),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mdl_pix(input int m, input int x, input int y, input int sh,
                                         input logic [7:0] ca, input logic [7:0] cb);
    case (m)
      0:       return ca;
      1:       return (y == 0 || y == V - 1) ? 8'hFF : 8'(x + y + sh);
      2:       return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? cb : ca;
      default: return 8'(y + sh);
    endcase
  endfunction

  function automatic logic [31:0] get_seen(input logic [31:0] a);
    return seen.exists(a) ? seen[a] : 32'hxxxxxxxx;
  endfunction

  // Drive pattern inputs and queue every word the next frame should write.
  task automatic push_frame(input int m, input logic [7:0] ca, input logic [7:0] cb);
    logic [31:0] base;
    exp_t        e;
    mode    = 2'(m);
    color_a = ca;
    color_b = cb;
    base = FB_BASE + (mdl_fbuf ? 32'd0 : STRIDE);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x += PPW) begin
        e.addr = base + (32'(y) << 10) + 32'(x * PIX_W / 8);
        for (int k = 0; k < PPW; k++)
          e.data[k*8 +: 8] = mdl_pix(m, x + k, y, mdl_shift, ca, cb);
        exp_q.push_back(e);
      end
    end
    mdl_shift = (mdl_shift == H - 1) ? 0 : mdl_shift + 1;
  endtask

  task automatic wait_drain();
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 20000) begin
      @(negedge clock);
      cnt++;
    end
    check_val("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_busy();
    int cnt = 0;
    while (!busy && cnt < 100) begin
      @(negedge clock);
      cnt++;
    end
    check_val("busy_start", busy, 1'b1);
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while ((busy || exp_q.size() != 0) && cnt < 500) begin
      @(negedge clock);
      cnt++;
    end
    check_val("idle_busy", busy, 1'b0);
    check_val("idle_queue", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_reqs(input int n);
    int target = n_req + n;
    int cnt = 0;
    while (n_req < target && cnt < 5000) begin
      @(negedge clock);
      cnt++;
    end
    check_val("req_progress", n_req >= target, 1'b1);
  endtask

  // Hold vsync low, raise it, and check the three-cycle swap latency.
  task automatic do_vsync();
    logic old;
    old = mdl_fbuf;
    repeat (100) @(negedge clock);
    check_val("busy_in_vsync_wait", busy, 1'b1);
    check_val("fbuf_before_vsync", fbuffer, old);
    exp_q.push_back('{addr: CTRL_A, data: {31'd0, ~old}});
    vsync = 1'b1;
    repeat (2) @(negedge clock);
    check_val("fbuf_latency", fbuffer, old);
    @(negedge clock);
    mdl_fbuf  = ~old;
    mdl_count = mdl_count + 16'd1;
    check_val("fbuf_swap", fbuffer, mdl_fbuf);
    check_val("frame_count", frame_count, mdl_count);
    vsync = 1'b0;
  endtask

  task automatic check_reset_vals();
    check_val("rst_valid", sd_in_valid, 1'b0);
    check_val("rst_rw", sd_rw, 1'b1);
    check_val("rst_addr", sd_addr, 32'd0);
    check_val("rst_data", sd_data_in, 32'd0);
    check_val("rst_wmask", sd_wmask, 4'hF);
    check_val("rst_fbuf", fbuffer, 1'b0);
    check_val("rst_count", frame_count, 16'd0);
    check_val("rst_busy", busy, 1'b0);
  endtask

  // Memory responder: scores each strobe, checks the hold window, answers.
  initial begin
    logic [31:0] cap_a;
    logic [31:0] cap_d;
    exp_t        e;
    bit          aborted;
    sd_done = 1'b0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && sd_in_valid === 1'b1) begin
        n_req++;
        cap_a = sd_addr;
        cap_d = sd_data_in;
        seen[cap_a] = cap_d;
        check_val("sb_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_val("addr", cap_a, e.addr);
          check_val("data", cap_d, e.data);
        end
        aborted = 1'b0;
        for (int i = 0; i < done_delay; i++) begin
          @(negedge clock);
          if (reset !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          check_val("hold_addr", sd_addr, cap_a);
          check_val("hold_data", sd_data_in, cap_d);
          check_val("no_restrobe", sd_in_valid, 1'b0);
        end
        if (!aborted) begin
          sd_done = 1'b1;
          @(negedge clock);
          sd_done = 1'b0;
          if (reset === 1'b1) begin
            check_val("single_strobe", sd_in_valid, 1'b0);
            check_val("hold_after_done", sd_addr, cap_a);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    enable      = 1'b0;
    mode        = 2'd0;
    color_a     = 8'h00;
    color_b     = 8'h00;
    vsync       = 1'b0;
    sd_data_out = 32'd0;
    repeat (3) @(negedge clock);
    check_reset_vals();
    reset = 1'b1;
    @(negedge clock);
    check_val("idle_after_reset", busy, 1'b0);

    // Frame A: bands at shift 0, single frame.
    seen.delete();
    push_frame(1, 8'h11, 8'h22);
    enable = 1'b1;
    wait_busy();
    enable = 1'b0;
    wait_drain();
    check_val("bands_x4_y1", get_seen(32'h40D00404), 32'h08070605);
    check_val("bands_row0", get_seen(32'h40D00000), 32'hFFFFFFFF);
    check_val("bands_last_row", get_seen(32'h40D09C3C), 32'hFFFFFFFF);
    do_vsync();
    wait_idle();

    // Frame B: solid colour with slow memory, into buffer 0.
    done_delay = 7;
    seen.delete();
    push_frame(0, 8'h5A, 8'h00);
    enable = 1'b1;
    wait_drain();
    check_val("solid_first", get_seen(32'h40C00000), 32'h5A5A5A5A);
    check_val("solid_last", get_seen(32'h40C09C3C), 32'h5A5A5A5A);
    do_vsync();

    // Frame C: checker, started back-to-back, enable dropped mid-frame.
    done_delay = 0;
    seen.delete();
    push_frame(2, 8'h00, 8'h01);
    wait_reqs(6);
    enable = 1'b0;
    wait_drain();
    check_val("chk_x32_y0", get_seen(32'h40D00020), 32'h01010101);
    check_val("chk_x32_y32", get_seen(32'h40D08020), 32'h00000000);
    check_val("chk_x0_y0", get_seen(32'h40D00000), 32'h00000000);
    do_vsync();
    wait_idle();

    // Frame D: gradient, interrupted by reset during a pending request.
    done_delay = 3;
    seen.delete();
    push_frame(3, 8'h00, 8'h00);
    enable = 1'b1;
    wait_reqs(20);
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_reset_vals();
    exp_q.delete();
    mdl_fbuf  = 1'b0;
    mdl_count = 16'd0;
    mdl_shift = 0;
    done_delay = 0;
    seen.delete();
    push_frame(0, 8'hA5, 8'h00);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Frame E: restart after reset lands in buffer 1 from the origin.
    wait_busy();
    enable = 1'b0;
    wait_drain();
    check_val("restart_first", get_seen(32'h40D00000), 32'hA5A5A5A5);
    do_vsync();
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
